// File: rtl/striping_pkg.sv
// Shared constants and helpers for the N-lane striping block.
// Optional lane parity is enabled by defining STRIPING_PARITY_EN.
package striping_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LANES   = 4;

    localparam int GATHER_WORD = 0;
    localparam int GATHER_BANK = 1;

    // Pointer width for n lanes; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/striping_lane_reg.sv
// One output lane: DATA_W register with load enable.
// With STRIPING_PARITY_EN defined, an even-parity bit is registered alongside.
module striping_lane_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
`ifdef STRIPING_PARITY_EN
    ,
    output logic              par
`endif
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

`ifdef STRIPING_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^d;
        end
    end
`endif

endmodule

// File: rtl/striping_nlane.sv
// Stripes an input word stream across LANES output lanes, per word or per gathered bank.
// Optional per-lane parity output lane_par is enabled by defining STRIPING_PARITY_EN.
module striping_nlane
    import striping_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int GATHER = GATHER_BANK
) (
    input  logic                            clk_2f,
    input  logic                            reset,
    input  logic                            valid_in,
    input  logic [DATA_W-1:0]               data_in,
    input  logic                            flush,
    output logic [LANES*DATA_W-1:0]         lane_data,
    output logic [LANES-1:0]                lane_valid,
    output logic                            bank_valid,
    output logic [striping_pkg::clog2(LANES)-1:0] lane_ptr
`ifdef STRIPING_PARITY_EN
    ,
    output logic [LANES-1:0]                lane_par
`endif
);

    localparam int PTR_W = clog2(LANES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

    logic [PTR_W-1:0]        ptr_q;
    logic [PTR_W-1:0]        ptr_d;
    logic [LANES-1:0]        load;
    logic [LANES-1:0]        valid_d;
    logic                    bank_d;
    logic                    publish;
    logic [LANES*DATA_W-1:0] load_data;
    logic [DATA_W-1:0]       stage_q [LANES];

    always_comb begin
        ptr_d     = ptr_q;
        load      = '0;
        valid_d   = '0;
        bank_d    = 1'b0;
        publish   = 1'b0;
        load_data = '0;

        // A word arriving in the publishing cycle bypasses staging into its lane.
        for (int k = 0; k < LANES; k++) begin
            if (GATHER == GATHER_WORD || (valid_in && ptr_q == PTR_W'(k))) begin
                load_data[k*DATA_W +: DATA_W] = data_in;
            end else begin
                load_data[k*DATA_W +: DATA_W] = stage_q[k];
            end
        end

        if (GATHER == GATHER_WORD) begin
            if (valid_in) begin
                ptr_d          = ptr_q + PTR_W'(1);
                load[ptr_q]    = 1'b1;
                valid_d[ptr_q] = 1'b1;
            end
        end else begin
            publish = (valid_in && ptr_q == PTR_LAST) ||
                      (flush && (ptr_q != '0 || valid_in));
            if (valid_in) begin
                ptr_d = ptr_q + PTR_W'(1);
            end
            if (publish) begin
                ptr_d  = '0;
                bank_d = 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    if (PTR_W'(k) < ptr_q || (valid_in && PTR_W'(k) == ptr_q)) begin
                        load[k]    = 1'b1;
                        valid_d[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            ptr_q      <= '0;
            lane_valid <= '0;
            bank_valid <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            lane_valid <= valid_d;
            bank_valid <= bank_d;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            for (int k = 0; k < LANES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (GATHER == GATHER_BANK && valid_in) begin
            stage_q[ptr_q] <= data_in;
        end
    end

    assign lane_ptr = ptr_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        striping_lane_reg #(
            .DATA_W(DATA_W)
        ) u_lane_reg (
            .clk   (clk_2f),
            .reset (reset),
            .load  (load[k]),
            .d     (load_data[k*DATA_W +: DATA_W]),
            .q     (lane_data[k*DATA_W +: DATA_W])
`ifdef STRIPING_PARITY_EN
            ,
            .par   (lane_par[k])
`endif
        );
    end

endmodule

// File: tb/tb_striping_nlane.sv
// Bench for striping_nlane: a 4-lane gathered instance and a 2-lane word-mode instance share one stimulus stream.
// Lane parity is checked when STRIPING_PARITY_EN is defined.
module tb_striping_nlane;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] data_in;
    logic        flush;

    logic [127:0] g_lane_data;
    logic [3:0]   g_lane_valid;
    logic         g_bank_valid;
    logic [1:0]   g_lane_ptr;

    logic [63:0]  w_lane_data;
    logic [1:0]   w_lane_valid;
    logic         w_bank_valid;
    logic [0:0]   w_lane_ptr;

`ifdef STRIPING_PARITY_EN
    logic [3:0]   g_lane_par;
    logic [1:0]   w_lane_par;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: gathered bank as a queue of pending words, word mode as a word counter.
    logic [31:0] bank_q[$];
    logic [31:0] g_exp_data [4];
    logic [3:0]  g_exp_valid;
    logic        g_exp_bank;
    logic [31:0] w_exp_data [2];
    logic [1:0]  w_exp_valid;
    int          w_count;

    always #5 clk_2f = ~clk_2f;

    striping_nlane #(.DATA_W(32), .LANES(4), .GATHER(1)) dut_g (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .flush      (flush),
        .lane_data  (g_lane_data),
        .lane_valid (g_lane_valid),
        .bank_valid (g_bank_valid),
        .lane_ptr   (g_lane_ptr)
`ifdef STRIPING_PARITY_EN
        ,
        .lane_par   (g_lane_par)
`endif
    );

    striping_nlane #(.DATA_W(32), .LANES(2), .GATHER(0)) dut_w (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .flush      (flush),
        .lane_data  (w_lane_data),
        .lane_valid (w_lane_valid),
        .bank_valid (w_bank_valid),
        .lane_ptr   (w_lane_ptr)
`ifdef STRIPING_PARITY_EN
        ,
        .lane_par   (w_lane_par)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bank_q.delete();
        for (int i = 0; i < 4; i++) g_exp_data[i] = '0;
        for (int i = 0; i < 2; i++) w_exp_data[i] = '0;
        g_exp_valid = '0;
        g_exp_bank  = 1'b0;
        w_exp_valid = '0;
        w_count     = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic f, input logic r);
        if (r) begin
            model_reset();
            return;
        end
        g_exp_valid = '0;
        g_exp_bank  = 1'b0;
        if (v) bank_q.push_back(d);
        if (bank_q.size() == 4 || (f && bank_q.size() > 0)) begin
            for (int i = 0; i < bank_q.size(); i++) begin
                g_exp_data[i]  = bank_q[i];
                g_exp_valid[i] = 1'b1;
            end
            g_exp_bank = 1'b1;
            bank_q.delete();
        end
        w_exp_valid = '0;
        if (v) begin
            w_exp_data[w_count % 2]  = d;
            w_exp_valid[w_count % 2] = 1'b1;
            w_count++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [127:0] g_packed;
        logic [63:0]  w_packed;
        g_packed = {g_exp_data[3], g_exp_data[2], g_exp_data[1], g_exp_data[0]};
        w_packed = {w_exp_data[1], w_exp_data[0]};
        check({tag, ".g_data"},  128'(g_lane_data),  g_packed);
        check({tag, ".g_valid"}, 128'(g_lane_valid), 128'(g_exp_valid));
        check({tag, ".g_bank"},  128'(g_bank_valid), 128'(g_exp_bank));
        check({tag, ".g_ptr"},   128'(g_lane_ptr),   128'(bank_q.size()));
        check({tag, ".w_data"},  128'(w_lane_data),  128'(w_packed));
        check({tag, ".w_valid"}, 128'(w_lane_valid), 128'(w_exp_valid));
        check({tag, ".w_bank"},  128'(w_bank_valid), 128'(0));
        check({tag, ".w_ptr"},   128'(w_lane_ptr),   128'(w_count % 2));
`ifdef STRIPING_PARITY_EN
        for (int i = 0; i < 4; i++)
            check({tag, ".g_par"}, 128'(g_lane_par[i]), 128'(^g_exp_data[i]));
        for (int i = 0; i < 2; i++)
            check({tag, ".w_par"}, 128'(w_lane_par[i]), 128'(^w_exp_data[i]));
`endif
    endtask

    task automatic cycle(input string tag, input logic v, input logic [31:0] d,
                         input logic f, input logic r);
        reset    = r;
        valid_in = v;
        data_in  = d;
        flush    = f;
        @(posedge clk_2f);
        model_step(v, d, f, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; valid_in = 1'b0; data_in = '0; flush = 1'b0;

        // Reset state, with stray inputs ignored while reset is high
        cycle("rst0", 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("rst1", 1'b1, 32'h12345678, 1'b1, 1'b1);

        // Full bank of four, published one cycle after the last word
        cycle("fb0", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        cycle("fb1", 1'b1, 32'hEEEEEEEE, 1'b0, 1'b0);
        cycle("fb2", 1'b1, 32'hDDDDDDDD, 1'b0, 1'b0);
        cycle("fb3", 1'b1, 32'hCCCCCCCC, 1'b0, 1'b0);
        cycle("fb4", 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        assert (g_lane_valid === 4'b0000 && g_lane_data[127:96] === 32'hCCCCCCCC) else begin
            errors++;
            $error("FAIL fb_hold: observed %b/%h expected 0000/cccccccc", g_lane_valid, g_lane_data[127:96]);
        end

        // Eight contiguous words: two back-to-back banks
        for (int i = 1; i <= 8; i++) cycle("b2b", 1'b1, 32'(i), 1'b0, 1'b0);
        cycle("b2b_idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // Partial bank flushed with no word; then flush with empty bank has no effect
        cycle("pf0", 1'b1, 32'h3, 1'b0, 1'b0);
        cycle("pf1", 1'b1, 32'h4, 1'b0, 1'b0);
        cycle("pf2", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("pf3", 1'b0, 32'h0, 1'b1, 1'b0);
        // Flush together with a word counts that word
        cycle("pf4", 1'b1, 32'h9, 1'b0, 1'b0);
        cycle("pf5", 1'b1, 32'hA, 1'b1, 1'b0);
        // Flush on an empty bank with a word publishes one slot
        cycle("pf6", 1'b1, 32'hB, 1'b1, 1'b0);

        // Word mode pattern from a clean start
        cycle("wm_rst", 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("wm0", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
        cycle("wm1", 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("wm2", 1'b1, 32'h00000005, 1'b0, 1'b0);

        // Reset mid-bank discards the partial bank
        cycle("mr_rst", 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("mr0", 1'b1, 32'h11111111, 1'b0, 1'b0);
        cycle("mr1", 1'b1, 32'h22222222, 1'b0, 1'b0);
        cycle("mr2", 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("mr3", 1'b1, 32'h00000005, 1'b0, 1'b0);
        cycle("mr4", 1'b0, 32'h0, 1'b1, 1'b0);

        // Parity-sensitive words
        cycle("par0", 1'b1, 32'h00000007, 1'b0, 1'b0);
        cycle("par1", 1'b1, 32'h00000003, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", ($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/striping_nlane.md
STRIPING_NLANE -- requirements
Module: striping_nlane

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32: word width in bits, 8..64.
REQ-002 The block SHALL expose parameter LANES, default 4: lane count, power of two, 2..8.
REQ-003 The block SHALL expose parameter GATHER, default 1: 0 = word mode, 1 = gathered-bank mode.
REQ-004 Port clk_2f  input  1  single clock; all logic SHALL sample on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port valid_in  input  1  data_in carries a word this cycle.
REQ-007 Port data_in  input  DATA_W  input word.
REQ-008 Port flush  input  1  publishes a partially filled bank (GATHER=1 only).
REQ-009 Port lane_data  output  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 Port lane_valid  output  LANES  per-lane valid, one bit per lane.
REQ-011 Port bank_valid  output  1  one-cycle pulse on each bank publish (GATHER=1), else tied 0.
REQ-012 Port lane_ptr  output  log2(LANES)  lane that receives the next valid word.

Function
REQ-013 lane_ptr SHALL advance by 1 modulo LANES on every cycle with valid_in=1, hold otherwise, and wrap from LANES-1 to 0.
REQ-014 Word mode: a valid word SHALL appear on lane lane_ptr one cycle later, with lane_valid one-hot on that lane for exactly one cycle.
REQ-015 Word mode: cycles with valid_in=0 SHALL give lane_valid=0 on the next cycle; lane_data SHALL hold the last written value of every lane.
REQ-016 Gathered mode: each valid word SHALL be written to staging slot lane_ptr; outputs SHALL stay unchanged until publish.
REQ-017 Gathered mode: the valid word that fills slot LANES-1 SHALL cause, on the next cycle, lane_data = full staging bank, lane_valid = all ones, and bank_valid = 1, each for one cycle.
REQ-018 Back-to-back: a valid word arriving in a publish cycle SHALL go into slot 0 of the new bank; throughput SHALL be one word per cycle with no stall.
REQ-019 flush=1 with lane_ptr>0 or valid_in=1 SHALL publish next cycle; lane_valid SHALL mark only filled slots (including a same-cycle word); lane_ptr SHALL return to 0.
REQ-020 flush=1 with lane_ptr=0 and valid_in=0 SHALL have no effect.
REQ-021 flush SHALL be ignored in word mode.
REQ-022 Latency SHALL be exactly one clk_2f cycle from the completing or flushing input cycle to the outputs.

Reset
REQ-023 While reset=1: lane_data, lane_valid, bank_valid, lane_ptr, staging bank and parity SHALL all be 0; valid_in and flush SHALL be ignored.
REQ-024 Reset asserted mid-bank SHALL discard the partial bank with no publish.
REQ-025 The first valid word after reset deasserts SHALL go to lane 0.

Configuration
REQ-026 With STRIPING_PARITY_EN defined, output lane_par [LANES] SHALL carry even parity of each lane's lane_data, registered with it and reset to 0.
REQ-027 Without STRIPING_PARITY_EN, port lane_par and its logic SHALL be absent.

Structure
REQ-028 Package striping_pkg SHALL hold the default DATA_W/LANES, the GATHER encodings, and a ptr-width function clog2.
REQ-029 One sub-module, striping_lane_reg (DATA_W register, load enable, optional parity), SHALL be instantiated once per lane.

Verification
REQ-030 GATHER=1, LANES=4: valid words FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on cycles 0-3 -> cycle 4: lanes 0..3 = FF..,EE..,DD..,CC.., lane_valid=1111, bank_valid=1.
REQ-031 GATHER=1: 8 contiguous words 1..8 -> publish {1,2,3,4} then, 4 cycles later, {5,6,7,8}; no gap, lane_ptr wraps 3->0.
REQ-032 GATHER=1: words 3, 4, then flush with valid_in=0 -> next cycle lanes 0/1 = 3/4, lane_valid=0011, lane_ptr=0.
REQ-033 Word mode, LANES=2: AAAAAAAA, idle, 00000005 -> lane0 valid=01, idle cycle valid=00, lane1=00000005 valid=10.
REQ-034 Reset pulsed after 2 words of a bank -> no publish, outputs 0; next word 00000005 lands in lane 0.
REQ-035 STRIPING_PARITY_EN defined: lane word 00000007 -> lane_par bit = 1; word 00000003 -> 0.
